// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and helpers for the time-sliced arbiter.
// State enum, default sizing, one-hot to index conversion.
package rr_arb_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam int N_DEF     = 4;
  localparam int CNT_W_DEF = 3;

  // Index of the set bit of a one-hot vector (up to 16 wide).
  function automatic logic [3:0] oh_to_idx(
    input logic [15:0] oh
  );
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) r |= 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: descending rotate-and-priority-encode winner select.
// Search starts at last_id-1 and wraps; last_id is the final candidate.
module rr_pick #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_id,
  output logic            win_vld,
  output logic [ID_W-1:0] win_id
);

  logic [ID_W-1:0] idx;

  // Walk the order backwards so the nearest candidate wins last.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int i = N; i >= 1; i--) begin
      idx = ID_W'((int'(last_id) + N - i) % N);
      if (req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_timeslice_n.sv
// rr_arb_timeslice_n: N-way round-robin arbiter, programmable slice.
// Zero-bubble handover, registered grant, id and slice-expiry flag.
module rr_arb_timeslice_n
  import rr_arb_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int ID_W  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [CNT_W-1:0] slice_len,
  output logic [N-1:0]     gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld,
  output logic             slice_exp
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] slice_q;
  logic [CNT_W-1:0] new_len;
  logic [ID_W-1:0]  last_id;
  logic [ID_W-1:0]  owner;
  logic [ID_W-1:0]  win_id;
  logic [N-1:0]     win_oh;
  logic             win_vld;
  logic             own_req;
  logic             expd;
  logic             rel;

  rr_pick #(
    .N(N)
  ) u_pick (
    .req    (req),
    .last_id(last_id),
    .win_vld(win_vld),
    .win_id (win_id)
  );

  assign owner   = ID_W'(oh_to_idx(16'(gnt)));
  assign own_req = req[owner];
  assign expd    = (cnt == slice_q);
  assign rel     = !own_req || expd;
  assign new_len = (slice_len == '0) ? CNT_W'(1) : slice_len;
  assign win_oh  = {{(N-1){1'b0}}, 1'b1} << win_id;
  assign gnt_vld = |gnt;

  // Grant FSM: start, hold, rotate or drop to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      last_id   <= '0;
      cnt       <= '0;
      slice_q   <= '0;
      slice_exp <= 1'b0;
    end else begin
      slice_exp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= BUSY;
            gnt     <= win_oh;
            gnt_id  <= win_id;
            last_id <= win_id;
            cnt     <= CNT_W'(1);
            slice_q <= new_len;
          end
        end
        BUSY: begin
          slice_exp <= own_req && expd;
          if (rel) begin
            if (win_vld) begin
              gnt     <= win_oh;
              gnt_id  <= win_id;
              last_id <= win_id;
              cnt     <= CNT_W'(1);
              slice_q <= new_len;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_timeslice_n.sv
// tb_rr_arb_timeslice_n: directed bench with a behavioural model.
// Model tracks owner, cycles used and slice length as integers.
module tb_rr_arb_timeslice_n;

  localparam int N  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [CW-1:0] slice_len;
  logic [N-1:0]  gnt;
  logic [1:0]    gnt_id;
  logic          gnt_vld;
  logic          slice_exp;

  int n_vec = 0;
  int n_bad = 0;

  int m_owner;
  int m_used;
  int m_len;
  int m_last;
  bit m_exp;

  bit         pin_on = 1'b0;
  logic [3:0] pin_gnt;
  bit         pin_exp;
  bit         async_chk = 1'b0;

  always #5 clk = ~clk;

  rr_arb_timeslice_n #(
    .N    (N),
    .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .slice_len(slice_len),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_vld  (gnt_vld),
    .slice_exp(slice_exp)
  );

  function automatic int pick(logic [N-1:0] r, int last);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (last - i + N) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_gnt(int o);
    logic [N-1:0] g;
    g = '0;
    if (o >= 0) g[o] = 1'b1;
    return g;
  endfunction

  // Behavioural model: owner, cycles used, slice, rotation point.
  always @(posedge clk or posedge rst) begin : model
    int  w;
    bit  drop;
    bit  ex;
    if (rst) begin
      m_owner <= -1;
      m_used  <= 0;
      m_len   <= 0;
      m_last  <= 0;
      m_exp   <= 1'b0;
    end else if (m_owner < 0) begin
      w = pick(req, m_last);
      m_exp <= 1'b0;
      if (w >= 0) begin
        m_owner <= w;
        m_used  <= 1;
        m_len   <= (slice_len == 0) ? 1 : int'(slice_len);
        m_last  <= w;
      end
    end else begin
      drop = !req[m_owner];
      ex   = (m_used == m_len);
      m_exp <= ex && !drop;
      if (drop || ex) begin
        w = pick(req, m_owner);
        if (w >= 0) begin
          m_owner <= w;
          m_used  <= 1;
          m_len   <= (slice_len == 0) ? 1 : int'(slice_len);
          m_last  <= w;
        end else begin
          m_owner <= -1;
        end
      end else begin
        m_used <= m_used + 1;
      end
    end
  end

  task automatic chk(string nm, int act, int want);
    n_vec++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, want, $time);
    end
  endtask

  // Compare DUT against the model each cycle, plus pinned literals.
  always @(negedge clk or posedge async_chk) begin
    if (rst) begin
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_id", int'(gnt_id), 0);
      chk("rst_vld", int'(gnt_vld), 0);
      chk("rst_exp", int'(slice_exp), 0);
    end else begin
      chk("gnt", int'(gnt), int'(model_gnt(m_owner)));
      chk("vld", int'(gnt_vld), int'(m_owner >= 0));
      chk("exp", int'(slice_exp), int'(m_exp));
      chk("onehot0", int'($onehot0(gnt)), 1);
      if (gnt_vld) chk("id", int'(gnt_id), m_owner);
      if (pin_on) begin
        chk("pin_gnt", int'(gnt), int'(pin_gnt));
        chk("pin_exp", int'(slice_exp), int'(pin_exp));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pin(logic [3:0] g, bit e);
    pin_on  = 1'b1;
    pin_gnt = g;
    pin_exp = e;
    tick();
    pin_on  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    slice_len = '0;
    repeat (3) tick();

    // Full contention, slice 4: 3,2,1,0,3 with expiry pulses.
    rst       = 1'b0;
    slice_len = 3'd4;
    req       = 4'b1111;
    for (int c = 1; c <= 17; c++) begin
      pin(4'b1000 >> (((c - 1) / 4) % 4), (c > 1) && ((c - 1) % 4 == 0));
    end

    // Drop to idle, then a short request from requester 2.
    req = '0;
    pin(4'b0000, 1'b0);
    tick();
    req = 4'b0100;
    pin(4'b0100, 1'b0);
    pin(4'b0100, 1'b0);
    req = '0;
    pin(4'b0000, 1'b0);
    pin(4'b0000, 1'b0);

    // Lone requester 1, slice 3: continuous grant, self-regrant.
    slice_len = 3'd3;
    req       = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      pin(4'b0010, (c > 1) && ((c - 1) % 3 == 0));
    end

    // Slice 0 acts as 1: requesters 0 and 1 alternate.
    req = '0;
    pin(4'b0000, 1'b0);
    slice_len = 3'd0;
    req       = 4'b0011;
    for (int c = 1; c <= 6; c++) begin
      pin((c % 2) ? 4'b0001 : 4'b0010, c > 1);
    end

    // Slice change mid-grant only affects the next owner.
    req = '0;
    pin(4'b0000, 1'b0);
    slice_len = 3'd4;
    req       = 4'b0100;
    pin(4'b0100, 1'b0);
    pin(4'b0100, 1'b0);
    slice_len = 3'd1;
    req       = 4'b0110;
    pin(4'b0100, 1'b0);
    pin(4'b0100, 1'b0);
    pin(4'b0010, 1'b1);
    pin(4'b0100, 1'b1);

    // Owner 1 mid-grant, then asynchronous reset.
    slice_len = 3'd4;
    req       = 4'b0010;
    pin(4'b0010, 1'b0);
    pin(4'b0010, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    async_chk = 1'b1;
    #1;
    async_chk = 1'b0;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    pin(4'b1000, 1'b0);
    pin(4'b1000, 1'b0);
    req = '0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
